// File: rtl/als_level_monitor.sv
// rtl/als_level_monitor.sv - periodic ALS light-code sampler, 4-sample average, hysteresis zone flag and interrupt
module als_level_monitor #(
    parameter int SAMPLE_PERIOD = 4194304,
    parameter int CNT_W         = 23
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [7:0]  thr_hi,
    input  logic [7:0]  thr_lo,
    input  logic        irq_en,
    input  logic        irq_ack,
    output logic [7:0]  level,
    output logic        level_valid,
    output logic        above,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SHIFT,
        ST_AVG,
        ST_CMP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [7:0]       win [4];
    logic [2:0]       fill;
    logic [9:0]       sum;
    logic             above_next;
    logic             unused_bits;

    assign unused_bits = ^{value[15:13], value[4:0]};
    assign tick        = (cnt == CNT_W'(SAMPLE_PERIOD - 1));
    assign sum         = {2'b00, win[0]} + {2'b00, win[1]} + {2'b00, win[2]} + {2'b00, win[3]};

    // Set test first so it wins when the thresholds are programmed inverted.
    always_comb begin
        above_next = above;
        if (level >= thr_hi) begin
            above_next = 1'b1;
        end else if (level < thr_lo) begin
            above_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_WAIT;
            for (int i = 0; i < 4; i++) begin
                win[i] <= 8'd0;
            end
            fill        <= 3'd0;
            level       <= 8'd0;
            level_valid <= 1'b0;
            above       <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (irq_ack) begin
                irq <= 1'b0;
            end
            case (state)
                ST_WAIT: begin
                    if (tick) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    win[0] <= value[12:5];
                    win[1] <= win[0];
                    win[2] <= win[1];
                    win[3] <= win[2];
                    if (fill != 3'd4) begin
                        fill <= fill + 3'd1;
                    end
                    state <= ST_AVG;
                end
                ST_AVG: begin
                    level       <= sum[9:2];
                    level_valid <= (fill == 3'd4);
                    state       <= ST_CMP;
                end
                ST_CMP: begin
                    if (level_valid) begin
                        above <= above_next;
                        // A new zone change overrides a simultaneous acknowledge.
                        if ((above_next != above) && irq_en) begin
                            irq <= 1'b1;
                        end
                    end
                    state <= ST_WAIT;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_als_level_monitor.sv
// tb/tb_als_level_monitor.sv - self-checking bench for als_level_monitor against a behavioural model
module tb_als_level_monitor;

    localparam int P = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [7:0]  thr_hi = 8'h80;
    logic [7:0]  thr_lo = 8'h40;
    logic        irq_en = 1'b1;
    logic        irq_ack = 1'b0;
    logic [7:0]  level;
    logic        level_valid;
    logic        above;
    logic        irq;

    int n_checks = 0;
    int n_err = 0;

    als_level_monitor #(.SAMPLE_PERIOD(P), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .value(value), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .irq_en(irq_en), .irq_ack(irq_ack), .level(level), .level_valid(level_valid),
        .above(above), .irq(irq)
    );

    always #5 clock = ~clock;

    // Reference: samples taken once per period, results appear in fixed cycles after each sample.
    int         m_cyc;
    int         hist[$];
    logic [7:0] m_level;
    logic       m_valid, m_above, m_irq;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cyc = 0;
            hist.delete();
            m_level = 0; m_valid = 0; m_above = 0; m_irq = 0;
        end else begin
            int  phase;
            bit  set_irq;
            logic new_above;
            phase = m_cyc % P;
            set_irq = 0;
            if (m_cyc >= P && phase == 0) begin
                hist.push_front(int'(value[12:5]));
                if (hist.size() > 4) void'(hist.pop_back());
            end
            if (m_cyc >= P && phase == 1) begin
                int s;
                s = 0;
                foreach (hist[i]) s += hist[i];
                m_level = 8'(s / 4);
                m_valid = (hist.size() == 4);
            end
            if (m_cyc >= P && phase == 2 && m_valid) begin
                if (m_level >= thr_hi) new_above = 1;
                else if (m_level < thr_lo) new_above = 0;
                else new_above = m_above;
                if (new_above != m_above && irq_en) set_irq = 1;
                m_above = new_above;
            end
            if (set_irq) m_irq = 1;
            else if (irq_ack) m_irq = 0;
            m_cyc++;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("level", 16'(level), 16'(m_level));
        check("level_valid", 16'(level_valid), 16'(m_valid));
        check("above", 16'(above), 16'(m_above));
        check("irq", 16'(irq), 16'(m_irq));
    end

    task automatic go_to(input int t);
        int guard;
        guard = 0;
        while (m_cyc < t && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        #1;
        if (m_cyc != t) begin
            n_checks++;
            n_err++;
            $display("FAIL go_to: reached cycle %0d required %0d", m_cyc, t);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_ack(input int t);
        go_to(t);
        irq_ack = 1'b1;
        go_to(t + 1);
        irq_ack = 1'b0;
    endtask

    initial begin
        // Ramp-up of a constant code 0x7F
        value = 16'h0FE0;
        do_reset();
        go_to(1*P+2); check("ramp1", 16'(level), 16'h1F); check("ramp1_v", 16'(level_valid), 16'h0);
        go_to(2*P+2); check("ramp2", 16'(level), 16'h3F);
        go_to(3*P+2); check("ramp3", 16'(level), 16'h5F); check("ramp3_v", 16'(level_valid), 16'h0);
        go_to(4*P+2); check("ramp4", 16'(level), 16'h7F); check("ramp4_v", 16'(level_valid), 16'h1);

        // Bright zone entry and exact irq latency
        value = 16'h1FE0;
        do_reset();
        go_to(4*P+2); check("bright_lvl", 16'(level), 16'hFF); check("bright_irq_early", 16'(irq), 16'h0);
        go_to(4*P+3); check("bright_above", 16'(above), 16'h1); check("bright_irq", 16'(irq), 16'h1);
        pulse_ack(4*P+3); check("ack_clears", 16'(irq), 16'h0);

        // Falling levels, above clears only below thr_lo
        value = 16'h0200;
        go_to(5*P+2); check("fall1", 16'(level), 16'hC3);
        go_to(6*P+2); check("fall2", 16'(level), 16'h87);
        go_to(7*P+3); check("fall3", 16'(level), 16'h4B); check("fall3_above", 16'(above), 16'h1);
        check("fall3_irq", 16'(irq), 16'h0);
        go_to(8*P+3); check("fall4", 16'(level), 16'h10); check("fall4_above", 16'(above), 16'h0);
        check("fall4_irq", 16'(irq), 16'h1);
        pulse_ack(8*P+4);

        // Settle between thresholds: zone holds
        value = 16'h0C00;
        go_to(12*P+3); check("hold_lvl", 16'(level), 16'h60); check("hold_above", 16'(above), 16'h0);
        check("hold_irq", 16'(irq), 16'h0);

        // Ack in the same cycle as a zone-change set
        value = 16'h1FE0;
        go_to(13*P+2);
        irq_ack = 1'b1;
        go_to(13*P+3);
        irq_ack = 1'b0;
        check("race_lvl", 16'(level), 16'h87); check("race_above", 16'(above), 16'h1);
        check("race_irq", 16'(irq), 16'h1);
        pulse_ack(13*P+4);

        // Masked zone change is lost
        irq_en = 1'b0;
        value = 16'h0200;
        go_to(17*P+3); check("mask_above", 16'(above), 16'h0); check("mask_irq", 16'(irq), 16'h0);
        irq_en = 1'b1;

        // Reset during AVG
        value = 16'h1FE0;
        go_to(18*P+1);
        reset = 1'b1;
        #1;
        check("rst_lvl", 16'(level), 16'h0); check("rst_v", 16'(level_valid), 16'h0);
        check("rst_above", 16'(above), 16'h0); check("rst_irq", 16'(irq), 16'h0);
        @(negedge clock);
        #1 reset = 1'b0;
        go_to(3*P+2); check("refill3_v", 16'(level_valid), 16'h0);
        go_to(4*P+2); check("refill4_v", 16'(level_valid), 16'h1); check("refill4_lvl", 16'(level), 16'hFF);

        // Randomized traffic checked by the per-cycle model comparison
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            #1;
            if ($urandom_range(0, 3) == 0) value = 16'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                thr_hi = 8'($urandom);
                thr_lo = 8'($urandom);
            end
            if ($urandom_range(0, 31) == 0) irq_en = ($urandom_range(0, 3) != 0);
            irq_ack = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 499) == 0);
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        irq_ack = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/als_level_monitor.md
Name: als_level_monitor

Overview:
- Consumes the 16-bit light-sensor word produced by the PMOD ALS SPI receiver.
- Samples the word on a fixed period and extracts the 8-bit ADC light code.
- Runs a 4-sample moving average and compares it against programmable high/low thresholds with hysteresis.
- Raises a level-sensitive, acknowledgeable interrupt toward the core's interrupt logic whenever the bright/dark zone changes.

Parameters:
- SAMPLE_PERIOD, 4194304, clock cycles between samples of value; legal range is ≥ 8, which matches the receiver's 2^22-cycle refresh.
- CNT_W, 23, width of the period counter; must satisfy 2^CNT_W > SAMPLE_PERIOD.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  16  raw receiver word; light code is value[12:5].
- thr_hi  input  8  set threshold; the above flag sets when avg ≥ thr_hi.
- thr_lo  input  8  clear threshold; the above flag clears when avg < thr_lo.
- irq_en  input  1  interrupt enable.
- irq_ack  input  1  one-cycle pulse that clears the pending interrupt.
- level  output  8  current 4-sample average.
- level_valid  output  1  high once 4 samples have been collected.
- above  output  1  hysteresis zone flag (1 = bright).
- irq  output  1  pending interrupt (level).

Behaviour:
- Reset is asynchronous, active-high, and may arrive at any time, including mid-sequence. It clears:
  - period counter, FSM → WAIT;
  - the 4-entry sample window to 0 and fill count to 0;
  - level=0, level_valid=0, above=0, irq=0.
- Period counter:
  - Free-running 0..SAMPLE_PERIOD-1, then wraps to 0.
  - tick=1 in the cycle the counter equals SAMPLE_PERIOD-1.
  - The counter never stalls.
- FSM states: WAIT → SHIFT → AVG → CMP → WAIT.
  - WAIT: on tick, go to SHIFT; otherwise stay.
  - SHIFT (1 cycle):
    - Push value[12:5], sampled on this clock edge, into window[0] and shift older entries down.
    - The oldest entry is discarded.
    - Fill count saturates at 4.
  - AVG (1 cycle):
    - sum = 10-bit sum of all 4 window entries.
    - level ← sum[9:2] (truncating divide by 4).
    - level_valid ← 1 if fill count == 4.
    - Before 4 samples, empty entries count as 0.
  - CMP (1 cycle):
    - Skipped in effect (no flag/irq change) while level_valid=0.
    - Otherwise, if level ≥ thr_hi then above ← 1; else if level < thr_lo then above ← 0; else above holds. The set test has priority when thr_lo > thr_hi.
    - If the new above differs from the old above and irq_en=1, set the irq pending bit.
- Latency:
  - level and level_valid change 2 cycles after the tick cycle.
  - above and irq change 3 cycles after the tick cycle.
- Interrupt:
  - irq = pending bit.
  - irq_ack=1 clears it on the next edge.
  - A set in CMP and irq_ack in the same cycle: set wins, irq stays 1.
  - irq_en=0 masks new sets only; an already-pending irq stays until acked.
  - Zone changes while irq_en=0 are lost; they are not latched.
- Thresholds and irq_en are sampled only in the CMP cycle; changes at other times have no effect until the next CMP.
- value may change at any time; only the value present in the SHIFT cycle is used.

Test Plan:
- Reset, then hold value=16'h0FE0 (code 0x7F) with SAMPLE_PERIOD=8 → level goes 0x1F, 0x3F, 0x5F, 0x7F after ticks 1-4; level_valid=0 until the 4th AVG, then 1.
- thr_hi=0x80, thr_lo=0x40, irq_en=1, 4 samples of 16'h1FE0 (0xFF) → level=0xFF, above=1, irq=1 exactly 3 cycles after tick 4.
- Pulse irq_ack → irq=0 next cycle. Then feed 16'h0200 (0x10) → level falls 0xC3, 0x87, 0x4B, 0x10; above clears only at 0x10 (< 0x40); irq re-asserts at that CMP.
- Hysteresis hold: level settles at 0x60 (between thresholds) → above unchanged, no irq.
- irq_ack asserted in the same cycle as a CMP zone change → irq remains 1.
- irq_en=0 during a zone change → above toggles, irq stays 0. Assert reset during AVG → all outputs 0 immediately; 4 fresh samples are needed before level_valid=1.
